// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// State encoding, default widths and requester IDs live here.
package alu_arb_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_OP_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic REQ_PIPE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker with optional ownership lock.
// i_prio names the requester that wins when both are valid.
module rr_arb2
    import alu_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_prio,
    input  logic       i_lock_en,
    input  logic       i_lock_owner,
    output logic [1:0] o_gnt
);

    // A held lock masks out the other requester entirely.
    always_comb begin
        o_gnt = 2'b00;
        if (i_lock_en) begin
            o_gnt = i_valid & id_to_onehot(i_lock_owner);
        end else if (&i_valid) begin
            o_gnt = id_to_onehot(i_prio);
        end else begin
            o_gnt = i_valid;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU and its N/Z flag registers between pipeline and aux requesters.
// Optional ownership lock enabled by defining ALU_ARB_LOCK_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned OP_W   = DEF_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req_op0,
    input  logic [OP_W-1:0]   req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [1:0]        req_fwe,
`ifdef ALU_ARB_LOCK_EN
    input  logic [1:0]        req_lock,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_n,
    input  logic              alu_z,
    output logic              nfcr,
    output logic              zfcr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_n,
    output logic              rsp_z
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rr_ptr;
    logic [1:0]          w_gnt;
    logic [1:0]          w_ready;
    logic                w_accept;
    logic                w_rsp_hs;
    logic                w_gnt_id;
    logic                w_lock_en;
    logic                w_lock_owner;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [OP_W-1:0]     r_op;
    logic                r_id;
    logic                r_fcr;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_n;
    logic                r_rsp_z;

    rr_arb2 u_rr_arb2 (
        .i_valid      (req_valid),
        .i_prio       (r_rr_ptr),
        .i_lock_en    (w_lock_en),
        .i_lock_owner (w_lock_owner),
        .o_gnt        (w_gnt)
    );

    assign w_gnt_id = w_gnt[REQ_AUX];
    assign w_accept = |w_ready;

`ifdef ALU_ARB_LOCK_EN
    logic r_lock_en;
    logic r_lock_owner;

    // Lock state is refreshed on every grant from the winner's lock bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock_en    <= 1'b0;
            r_lock_owner <= REQ_PIPE;
        end else if (w_accept) begin
            r_lock_en    <= req_lock[w_gnt_id];
            r_lock_owner <= w_gnt_id;
        end
    end

    assign w_lock_en    = r_lock_en;
    assign w_lock_owner = r_lock_owner;
`else
    assign w_lock_en    = 1'b0;
    assign w_lock_owner = REQ_PIPE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ready is gated by reset so nothing is offered while the block is held.
    always_comb begin
        w_ready  = 2'b00;
        w_rsp_hs = r_rsp_valid & rsp_ready;
        if ((r_state == ST_IDLE) && rst) begin
            w_ready = w_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= REQ_PIPE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= REQ_PIPE;
            r_fcr       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_n     <= 1'b0;
            r_rsp_z     <= 1'b0;
        end else begin
            r_fcr <= 1'b0;
            if (w_accept) begin
                r_a      <= w_gnt_id ? req_a1  : req_a0;
                r_b      <= w_gnt_id ? req_b1  : req_b0;
                r_op     <= w_gnt_id ? req_op1 : req_op0;
                r_fcr    <= req_fwe[w_gnt_id];
                r_id     <= w_gnt_id;
                r_rr_ptr <= ~w_gnt_id;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data  <= alu_res;
                r_rsp_n     <= alu_n;
                r_rsp_z     <= alu_z;
                r_rsp_valid <= 1'b1;
            end else if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready = w_ready;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign nfcr      = r_fcr;
    assign zfcr      = r_fcr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_n     = r_rsp_n;
    assign rsp_z     = r_rsp_z;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and response scoreboard.
// Lock scenario is compiled in when ALU_ARB_LOCK_EN is defined.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       n;
        logic       z;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready, req_fwe;
    logic [3:0] req_op0, req_op1, alu_op;
    logic [7:0] req_a0, req_a1, req_b0, req_b1, alu_a, alu_b, alu_res, rsp_data;
    logic       alu_n, alu_z, nfcr, zfcr, rsp_valid, rsp_ready, rsp_id, rsp_n, rsp_z;
`ifdef ALU_ARB_LOCK_EN
    logic [1:0] req_lock;
`endif

    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    logic exp_fcr = 1'b0;
    rsp_t sb[$];
    int   gseq[$];
    int   gtime[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = a - b;
            4'd2:    alu_f = a & b;
            4'd3:    alu_f = a | b;
            4'd4:    alu_f = a ^ b;
            default: alu_f = a;
        endcase
    endfunction

    assign alu_res = alu_f(alu_op, alu_a, alu_b);
    assign alu_n   = alu_res[7];
    assign alu_z   = (alu_res == 8'h00);

    alu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .req_fwe   (req_fwe),
`ifdef ALU_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_res   (alu_res),
        .alu_n     (alu_n),
        .alu_z     (alu_z),
        .nfcr      (nfcr),
        .zfcr      (zfcr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_n     (rsp_n),
        .rsp_z     (rsp_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t make_exp(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        rsp_t e;
        e.id   = id;
        e.data = alu_f(op, a, b);
        e.n    = e.data[7];
        e.z    = (e.data == 8'h00);
        return e;
    endfunction

    // Scoreboard: push on request handshake, pop on response handshake; flag enables tracked per cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            exp_fcr <= 1'b0;
        end else begin
            chk("nfcr", 32'(nfcr), 32'(exp_fcr));
            chk("zfcr", 32'(zfcr), 32'(exp_fcr));
            exp_fcr <= 1'b0;
            if (req_valid[0] && req_ready[0]) begin
                sb.push_back(make_exp(1'b0, req_op0, req_a0, req_b0));
                gseq.push_back(0);
                gtime.push_back(cyc);
                exp_fcr <= req_fwe[0];
            end
            if (req_valid[1] && req_ready[1]) begin
                sb.push_back(make_exp(1'b1, req_op1, req_a1, req_b1));
                gseq.push_back(1);
                gtime.push_back(cyc);
                exp_fcr <= req_fwe[1];
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    rsp_t e;
                    e = sb.pop_front();
                    chk("rsp_id",   32'(rsp_id),   32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_n",    32'(rsp_n),    32'(e.n));
                    chk("rsp_z",    32'(rsp_z),    32'(e.z));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        gseq.delete();
        gtime.delete();
    endtask

    task automatic rand_payload(input int id);
        if (id == 0) begin
            req_op0    = 4'($urandom_range(0, 5));
            req_a0     = 8'($urandom);
            req_b0     = 8'($urandom);
            req_fwe[0] = 1'($urandom);
        end else begin
            req_op1    = 4'($urandom_range(0, 5));
            req_a1     = 8'($urandom);
            req_b1     = 8'($urandom);
            req_fwe[1] = 1'($urandom);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1;
        logic [1:0] w;
        rst = 1'b0; rsp_ready = 1'b1; req_fwe = 2'b00;
        req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        req_valid = 2'b11;
`ifdef ALU_ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        @(negedge clk);
        chk("rst_ctrl", 32'({req_ready, alu_a, alu_b, alu_op, nfcr, zfcr}), 32'd0);
        chk("rst_rsp",  32'({rsp_valid, rsp_id, rsp_data, rsp_n, rsp_z}), 32'd0);
        req_valid = 2'b00;
        tick();
        rst = 1'b1;

        // Single requester 0: ADD 5+3 with flag write.
        tick();
        req_op0 = OP_ADD; req_a0 = 8'h05; req_b0 = 8'h03; req_fwe = 2'b01; req_valid = 2'b01;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t1_exec_fcr", 32'({nfcr, zfcr}), 32'd3);
        chk("t1_exec_alu", 32'({alu_op, alu_a, alu_b}), 32'({OP_ADD, 8'h05, 8'h03}));
        chk("t1_exec_rspv", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_resp_fcr", 32'({nfcr, zfcr}), 32'd0);
        chk("t1_resp", 32'({rsp_valid, rsp_id, rsp_data, rsp_n, rsp_z}), 32'({1'b1, 1'b0, 8'h08, 1'b0, 1'b0}));
        @(negedge clk);
        chk("t1_idle_rspv", 32'(rsp_valid), 32'd0);

        // Non-flag op producing zero.
        tick();
        req_op0 = OP_SUB; req_a0 = 8'h07; req_b0 = 8'h07; req_fwe = 2'b00; req_valid = 2'b01;
        @(negedge clk);
        chk("t3_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("t3_exec_fcr", 32'({nfcr, zfcr}), 32'd0);
        @(negedge clk);
        chk("t3_resp", 32'({rsp_valid, rsp_data, rsp_n, rsp_z}), 32'({1'b1, 8'h00, 1'b0, 1'b1}));

        // Backpressure on the response with a pending request behind it.
        tick();
        rsp_ready = 1'b0;
        req_op1 = OP_XOR; req_a1 = 8'h5A; req_b1 = 8'hA5; req_fwe = 2'b10; req_valid = 2'b10;
        @(negedge clk);
        chk("t4_ready1", 32'(req_ready), 32'd2);
        tick();
        req_op0 = OP_OR; req_a0 = 8'h80; req_b0 = 8'h01; req_fwe = 2'b01; req_valid = 2'b01;
        @(negedge clk);
        chk("t4_exec_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_bp_rsp", 32'({rsp_valid, rsp_id, rsp_data, rsp_n}), 32'({1'b1, 1'b1, 8'hFF, 1'b1}));
            chk("t4_bp_ready", 32'(req_ready), 32'd0);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_hs_ready", 32'({rsp_valid, req_ready}), 32'({1'b1, 2'b00}));
        tick();
        @(negedge clk);
        chk("t4_pending_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        repeat (4) @(negedge clk);

        // Both valid continuously: alternating grants from requester 0.
        do_reset();
        rand_payload(0);
        rand_payload(1);
        req_valid = 2'b11;
        for (int c = 0; c < 40 && gseq.size() < 6; c++) begin
            @(negedge clk);
            w = req_ready;
            tick();
            if (w[0]) rand_payload(0);
            if (w[1]) rand_payload(1);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        chk("t2_grants", 32'(gseq.size()), 32'd6);
        for (int i = 0; i < gseq.size() && i < 6; i++) begin
            chk("t2_order", 32'(gseq[i]), 32'(i % 2));
            if (i > 0) chk("t2_spacing", 32'(gtime[i] - gtime[i-1]), 32'd3);
        end

        // Reset asserted during EXEC.
        tick();
        req_op0 = OP_ADD; req_a0 = 8'h11; req_b0 = 8'h22; req_fwe = 2'b01; req_valid = 2'b01;
        @(negedge clk);
        chk("t5_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        #2 rst = 1'b0;
        #1;
        chk("t5_async_ctrl", 32'({req_ready, alu_a, alu_b, alu_op, nfcr, zfcr}), 32'd0);
        chk("t5_async_rsp",  32'({rsp_valid, rsp_id, rsp_data, rsp_n, rsp_z}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        rand_payload(0);
        rand_payload(1);
        req_valid = 2'b11;
        @(negedge clk);
        chk("t5_prio", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        repeat (4) @(negedge clk);

`ifdef ALU_ARB_LOCK_EN
        // Requester 1 locks ownership until it issues an unlocked op.
        tick();
        rand_payload(0);
        req_valid = 2'b01;
        @(negedge clk);
        tick();
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        gseq.delete();
        gtime.delete();
        n1 = 0;
        rand_payload(0);
        rand_payload(1);
        req_lock = 2'b10;
        req_valid = 2'b11;
        for (int c = 0; c < 60 && gseq.size() < 5; c++) begin
            @(negedge clk);
            w = req_ready;
            tick();
            if (w[1]) begin
                n1++;
                if (n1 == 3) req_lock[1] = 1'b0;
                rand_payload(1);
            end
            if (w[0]) rand_payload(0);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        chk("t6_grants", 32'(gseq.size()), 32'd5);
        for (int i = 0; i < gseq.size() && i < 5; i++) begin
            chk("t6_order", 32'(gseq[i]), (i < 4) ? 32'd1 : 32'd0);
        end
`else
        n1 = 0;
`endif

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
